// File: rtl/multiword_add_sequencer.sv
// ============================================================================
//  Module      : multiword_add_sequencer
//  Description : Steps an external 4-bit adder slice across WORDS nibbles to
//                form a 4*WORDS-bit add/subtract, least significant first.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*WORDS-1:0]   a_in,
  input  logic [4*WORDS-1:0]   b_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);

  localparam int N  = 4 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IW+1:0]   w_bit_pos;

  assign w_bit_pos = {idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry.
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[w_bit_pos +: 4];
        add_b   = b_q[w_bit_pos +: 4];
        add_cin = carry_q;
        sum_d[w_bit_pos +: 4] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[3] != a_q[N-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire
